// File: rtl/imem_prog_loader.sv
// Instruction-memory program loader: assembles a byte stream into 32-bit words and writes
// them to consecutive addresses, holding the CPU until a complete image is in place.
// Optional trailing XOR checksum byte: define LOADER_CHECKSUM_EN.
module imem_prog_loader #(
  parameter int                ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              im_we,
  output logic              cpu_run,
  output logic              load_done,
  output logic              load_err
);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_HDR, S_LOAD, S_WRITE, S_CSUM, S_DONE, S_ERR} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_HDR, S_LOAD, S_WRITE, S_DONE, S_ERR} state_t;
`endif

  // Capacity as a 17-bit constant so an N of exactly 2**ADDR_W is still legal.
  localparam logic [16:0] CAP = 17'(2 ** ADDR_W);

  state_t      state;
  logic [31:0] word;
  logic [1:0]  byte_cnt;
  logic [15:0] word_cnt;
  logic [15:0] word_total;
  logic [7:0]  csum;
  logic        xfer;
  logic [31:0] word_next;
  logic [15:0] hdr_n;
  logic [15:0] word_cnt_inc;

  always_comb begin
    xfer         = rx_valid & rx_ready;
    word_next    = {word[23:0], rx_data};
    hdr_n        = {word[7:0], rx_data};
    word_cnt_inc = word_cnt + 16'd1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      rx_ready   <= 1'b0;
      im_we      <= 1'b0;
      cpu_run    <= 1'b0;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
      im_addr    <= BASE_ADDR;
      im_wdata   <= '0;
      word       <= '0;
      byte_cnt   <= '0;
      word_cnt   <= '0;
      word_total <= '0;
      csum       <= '0;
    end else begin
      im_we <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            cpu_run   <= 1'b0;
            load_done <= 1'b0;
            load_err  <= 1'b0;
            im_addr   <= BASE_ADDR;
            byte_cnt  <= '0;
            word_cnt  <= '0;
            csum      <= '0;
            rx_ready  <= 1'b1;
            state     <= S_HDR;
          end
        end
        S_HDR: begin
          if (xfer) begin
            word     <= word_next;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd1) begin
              byte_cnt   <= '0;
              word_total <= hdr_n;
              if (hdr_n == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
                state <= S_CSUM;
`else
                rx_ready  <= 1'b0;
                cpu_run   <= 1'b1;
                load_done <= 1'b1;
                state     <= S_DONE;
`endif
              end else if ({1'b0, hdr_n} > CAP) begin
                rx_ready <= 1'b0;
                load_err <= 1'b1;
                state    <= S_ERR;
              end else begin
                state <= S_LOAD;
              end
            end
          end
        end
        S_LOAD: begin
          if (xfer) begin
            word     <= word_next;
            csum     <= csum ^ rx_data;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              im_wdata <= word_next;
              im_we    <= 1'b1;
              rx_ready <= 1'b0;
              state    <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          im_addr  <= im_addr + 1'b1;
          word_cnt <= word_cnt_inc;
          if (word_cnt_inc == word_total) begin
`ifdef LOADER_CHECKSUM_EN
            rx_ready <= 1'b1;
            state    <= S_CSUM;
`else
            cpu_run   <= 1'b1;
            load_done <= 1'b1;
            state     <= S_DONE;
`endif
          end else begin
            rx_ready <= 1'b1;
            state    <= S_LOAD;
          end
        end
`ifdef LOADER_CHECKSUM_EN
        S_CSUM: begin
          if (xfer) begin
            rx_ready <= 1'b0;
            if (rx_data == csum) begin
              cpu_run   <= 1'b1;
              load_done <= 1'b1;
              state     <= S_DONE;
            end else begin
              load_err <= 1'b1;
              state    <= S_ERR;
            end
          end
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_prog_loader.sv
// Directed bench for imem_prog_loader: nominal, gapped, empty, oversize and reset-abort loads,
// plus the checksum cases when LOADER_CHECKSUM_EN is defined.
module tb_imem_prog_loader;
  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [7:0] rx_data = '0;
  logic       rx_valid = 1'b0;
  logic       rx_ready;
  logic [7:0] im_addr;
  logic [31:0] im_wdata;
  logic       im_we, cpu_run, load_done, load_err;

  int errors = 0;
  int checks = 0;
  int wn = 0;
  logic [7:0]  wa [16];
  logic [31:0] wd [16];
  logic [7:0]  img [10] = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78,
                            8'h9A, 8'hBC, 8'hDE, 8'hF0};

  imem_prog_loader #(.ADDR_W(8), .BASE_ADDR(8'h00)) dut (
    .clock(clock), .reset(reset), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .im_addr(im_addr), .im_wdata(im_wdata), .im_we(im_we),
    .cpu_run(cpu_run), .load_done(load_done), .load_err(load_err)
  );

  always #5 clock = ~clock;

  // Record every write strobe, sampled on the falling edge.
  always @(negedge clock) begin
    if (im_we === 1'b1) begin
      if (wn < 16) begin
        wa[wn] = im_addr;
        wd[wn] = im_wdata;
      end
      wn++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    repeat (gap) @(negedge clock);
    @(negedge clock);
    rx_data  = b;
    rx_valid = 1'b1;
    n = 0;
    while (rx_ready !== 1'b1 && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (n >= 50) chk("rx_ready_timeout", 32'(rx_ready), 32'd1);
    else @(posedge clock);
    #1 rx_valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clock) start = 1'b1;
    @(negedge clock) start = 1'b0;
  endtask

  task automatic load_and_check(input int gapmax, input bit mid_start);
    int wb;
    wb = wn;
    pulse_start();
    chk("start_cpu_run", 32'(cpu_run), 32'd0);
    chk("start_done_clr", 32'(load_done), 32'd0);
    chk("start_err_clr", 32'(load_err), 32'd0);
    chk("hdr_rx_ready", 32'(rx_ready), 32'd1);
    for (int i = 0; i < 10; i++) begin
      if (mid_start && i == 5) pulse_start();
      send_byte(img[i], gapmax == 0 ? 0 : int'($urandom_range(0, gapmax)));
    end
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h00, 0);
    @(negedge clock);
    chk("csum_done", 32'(load_done), 32'd1);
    chk("csum_cpu_run", 32'(cpu_run), 32'd1);
`else
    @(negedge clock);
    chk("last_we", 32'(im_we), 32'd1);
    chk("last_addr", 32'(im_addr), 32'd1);
    chk("last_wdata", im_wdata, 32'h9ABCDEF0);
    chk("last_cpu_held", 32'(cpu_run), 32'd0);
    @(negedge clock);
    chk("done_cpu_run", 32'(cpu_run), 32'd1);
    chk("done_flag", 32'(load_done), 32'd1);
    chk("done_we_low", 32'(im_we), 32'd0);
`endif
    repeat (4) @(negedge clock);
    chk("img_write_count", 32'(wn - wb), 32'd2);
    chk("img_addr0", 32'(wa[wb]), 32'h00);
    chk("img_data0", wd[wb], 32'h12345678);
    chk("img_addr1", 32'(wa[wb+1]), 32'h01);
    chk("img_data1", wd[wb+1], 32'h9ABCDEF0);
    chk("img_cpu_run_hold", 32'(cpu_run), 32'd1);
    chk("img_rx_ready_done", 32'(rx_ready), 32'd0);
  endtask

  initial begin
    int wb;
    // Reset values
    #1;
    chk("rst_rx_ready", 32'(rx_ready), 32'd0);
    chk("rst_we", 32'(im_we), 32'd0);
    chk("rst_cpu_run", 32'(cpu_run), 32'd0);
    chk("rst_done", 32'(load_done), 32'd0);
    chk("rst_err", 32'(load_err), 32'd0);
    chk("rst_addr", 32'(im_addr), 32'd0);
    chk("rst_wdata", im_wdata, 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("idle_rx_ready", 32'(rx_ready), 32'd0);

    // Back-to-back image, then gapped image with an ignored start mid-stream
    load_and_check(0, 1'b0);
    load_and_check(3, 1'b1);

    // Empty image
    wb = wn;
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h00, 0);
`endif
    @(negedge clock);
    chk("empty_done", 32'(load_done), 32'd1);
    chk("empty_cpu_run", 32'(cpu_run), 32'd1);
    chk("empty_rx_ready", 32'(rx_ready), 32'd0);
    repeat (3) @(negedge clock);
    chk("empty_writes", 32'(wn - wb), 32'd0);

    // Oversize header N=257, then recovery
    wb = wn;
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h01, 0);
    @(negedge clock);
    chk("big_err", 32'(load_err), 32'd1);
    chk("big_cpu_run", 32'(cpu_run), 32'd0);
    chk("big_done", 32'(load_done), 32'd0);
    chk("big_rx_ready", 32'(rx_ready), 32'd0);
    repeat (3) @(negedge clock);
    chk("big_writes", 32'(wn - wb), 32'd0);
    load_and_check(0, 1'b0);

    // Reset after 6 of 10 bytes, once the loader is back in LOAD at address 1
    wb = wn;
    pulse_start();
    for (int i = 0; i < 6; i++) send_byte(img[i], 0);
    @(negedge clock);
    @(negedge clock);
    chk("abort_partial_writes", 32'(wn - wb), 32'd1);
    chk("abort_pre_addr", 32'(im_addr), 32'd1);
    reset = 1'b0;
    #1;
    chk("abort_rx_ready", 32'(rx_ready), 32'd0);
    chk("abort_we", 32'(im_we), 32'd0);
    chk("abort_cpu_run", 32'(cpu_run), 32'd0);
    chk("abort_addr", 32'(im_addr), 32'd0);
    chk("abort_wdata", im_wdata, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    load_and_check(1, 1'b0);

`ifdef LOADER_CHECKSUM_EN
    // Single-word image with good then bad checksum
    wb = wn;
    pulse_start();
    send_byte(8'h00, 0); send_byte(8'h01, 0);
    send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0); send_byte(8'h44, 0);
    send_byte(8'h44, 0);
    @(negedge clock);
    chk("cs_ok_done", 32'(load_done), 32'd1);
    chk("cs_ok_cpu_run", 32'(cpu_run), 32'd1);
    chk("cs_ok_data", wd[wb], 32'h11223344);
    pulse_start();
    send_byte(8'h00, 0); send_byte(8'h01, 0);
    send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0); send_byte(8'h44, 0);
    send_byte(8'h45, 0);
    @(negedge clock);
    chk("cs_bad_err", 32'(load_err), 32'd1);
    chk("cs_bad_cpu_run", 32'(cpu_run), 32'd0);
    chk("cs_bad_done", 32'(load_done), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
